// File: rtl/median_filter_host_bridge_pkg.sv
// Shared definitions for the median filter host bridge: port address modes and FSM state codes.
package median_filter_host_bridge_pkg;

    localparam logic [1:0] MODE_PIX  = 2'b00;
    localparam logic [1:0] MODE_CTRL = 2'b01;
    localparam logic [1:0] MODE_W    = 2'b10;
    localparam logic [1:0] MODE_H    = 2'b11;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_LOAD      = 4'd1;
    localparam state_t S_CFG_W     = 4'd2;
    localparam state_t S_CFG_H     = 4'd3;
    localparam state_t S_START     = 4'd4;
    localparam state_t S_POLL_REQ  = 4'd5;
    localparam state_t S_POLL_WAIT = 4'd6;
    localparam state_t S_RD_REQ    = 4'd7;
    localparam state_t S_RD_WAIT   = 4'd8;
    localparam state_t S_RD_OUT    = 4'd9;

endpackage

// File: rtl/median_filter_host_bridge_if.sv
// Memory-mapped port of median_filter_unit; the bridge is the master side.
interface median_filter_host_bridge_if #(
    parameter int ADDR_WIDTH      = 18,
    parameter int MODE_ADDR_WIDTH = 2,
    parameter int FULL_BIT_WIDTH  = 32
);
    logic [FULL_BIT_WIDTH-1:0]             dina_o;
    logic [MODE_ADDR_WIDTH+ADDR_WIDTH-1:0] addra_o;
    logic                                  wea_o;
    logic                                  ena_o;
    logic [FULL_BIT_WIDTH-1:0]             douta_i;

    modport master (output dina_o, addra_o, wea_o, ena_o, input douta_i);
    modport slave  (input dina_o, addra_o, wea_o, ena_o, output douta_i);
endinterface

// File: rtl/median_filter_host_bridge_port_seq.sv
// Single-access sequencer: registers one request onto the filter port and flags read data
// RD_LATENCY cycles after the access cycle.
module median_filter_port_seq #(
    parameter int ADDR_WIDTH      = 18,
    parameter int MODE_ADDR_WIDTH = 2,
    parameter int FULL_BIT_WIDTH  = 32,
    parameter int RD_LATENCY      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    median_filter_host_bridge_if.master           fport,
    input  logic                                  req,
    input  logic                                  we,
    input  logic [MODE_ADDR_WIDTH+ADDR_WIDTH-1:0] addr,
    input  logic [FULL_BIT_WIDTH-1:0]             wdata,
    output logic                                  rdata_valid,
    output logic [FULL_BIT_WIDTH-1:0]             rdata
);
    // Bit 0 marks the read access cycle; bit RD_LATENCY marks the cycle douta is valid.
    logic [RD_LATENCY:0] rd_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            fport.ena_o   <= 1'b0;
            fport.wea_o   <= 1'b0;
            fport.addra_o <= '0;
            fport.dina_o  <= '0;
            rd_pipe       <= '0;
        end else begin
            fport.ena_o <= req;
            fport.wea_o <= req & we;
            if (req) begin
                fport.addra_o <= addr;
                fport.dina_o  <= wdata;
            end
            rd_pipe <= {rd_pipe[RD_LATENCY-1:0], req & ~we};
        end
    end

    assign rdata_valid = rd_pipe[RD_LATENCY];
    assign rdata       = fport.douta_i;

endmodule

// File: rtl/median_filter_host_bridge.sv
// Host bridge: streams pixels into median_filter_unit, programs and starts it, polls for
// completion, then streams the filtered image back out.
module median_filter_host_bridge
    import median_filter_host_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 18,
    parameter int MODE_ADDR_WIDTH = 2,
    parameter int FULL_BIT_WIDTH  = 32,
    parameter int BIT_WIDTH       = 8,
    parameter int DIM_WIDTH       = 10,
    parameter int RD_LATENCY      = 1,
    parameter int POLL_TIMEOUT    = 1 << 24
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DIM_WIDTH-1:0]       cfg_width_i,
    input  logic [DIM_WIDTH-1:0]       cfg_height_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    input  logic [BIT_WIDTH-1:0]       s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic [BIT_WIDTH-1:0]       m_data_o,
    output logic                       m_valid_o,
    output logic                       m_last_o,
    input  logic                       m_ready_i,
    median_filter_host_bridge_if.master fport
);
    localparam int PROD_W = 2 * DIM_WIDTH;
    localparam int CMP_W  = (PROD_W > ADDR_WIDTH + 1) ? PROD_W : ADDR_WIDTH + 1;
    localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);
    localparam int AW     = MODE_ADDR_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

    state_t                    state;
    logic [DIM_WIDTH-1:0]      w_q, h_q;
    logic [ADDR_WIDTH:0]       npix, idx, idx_next;
    logic [POLL_W-1:0]         poll_cnt;
    logic [CMP_W-1:0]          npix_c;
    logic                      size_bad, in_hs;
    logic                      req, req_we, rdata_valid;
    logic [AW-1:0]             req_addr;
    logic [FULL_BIT_WIDTH-1:0] req_wdata, rdata;

    assign npix_c   = CMP_W'(cfg_width_i) * CMP_W'(cfg_height_i);
    assign size_bad = (cfg_width_i == '0) || (cfg_height_i == '0) ||
                      (npix_c > (CMP_W'(1) << ADDR_WIDTH));
    assign idx_next = idx + IDX_ONE;
    assign in_hs    = s_valid_i && s_ready_o;
    assign busy_o   = (state != S_IDLE);

    always_comb begin
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state)
            S_LOAD: if (in_hs) begin
                req       = 1'b1;
                req_we    = 1'b1;
                req_addr  = {MODE_ADDR_WIDTH'(MODE_PIX), idx[ADDR_WIDTH-1:0]};
                req_wdata = FULL_BIT_WIDTH'(s_data_i);
            end
            S_CFG_W: begin
                req = 1'b1; req_we = 1'b1;
                req_addr  = {MODE_ADDR_WIDTH'(MODE_W), ADDR_WIDTH'(0)};
                req_wdata = FULL_BIT_WIDTH'(w_q);
            end
            S_CFG_H: begin
                req = 1'b1; req_we = 1'b1;
                req_addr  = {MODE_ADDR_WIDTH'(MODE_H), ADDR_WIDTH'(0)};
                req_wdata = FULL_BIT_WIDTH'(h_q);
            end
            S_START: begin
                req = 1'b1; req_we = 1'b1;
                req_addr  = {MODE_ADDR_WIDTH'(MODE_CTRL), ADDR_WIDTH'(0)};
                req_wdata = FULL_BIT_WIDTH'(1);
            end
            S_POLL_REQ: begin
                req      = 1'b1;
                req_addr = {MODE_ADDR_WIDTH'(MODE_CTRL), ADDR_WIDTH'(0)};
            end
            S_RD_REQ: begin
                req      = 1'b1;
                req_addr = {MODE_ADDR_WIDTH'(MODE_PIX), idx[ADDR_WIDTH-1:0]};
            end
            default: ;
        endcase
    end

    median_filter_port_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .MODE_ADDR_WIDTH(MODE_ADDR_WIDTH),
        .FULL_BIT_WIDTH (FULL_BIT_WIDTH),
        .RD_LATENCY     (RD_LATENCY)
    ) u_port_seq (
        .clk        (CLK),
        .rst        (RST),
        .fport      (fport),
        .req        (req),
        .we         (req_we),
        .addr       (req_addr),
        .wdata      (req_wdata),
        .rdata_valid(rdata_valid),
        .rdata      (rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            w_q       <= '0;
            h_q       <= '0;
            npix      <= '0;
            idx       <= '0;
            poll_cnt  <= '0;
            s_ready_o <= 1'b0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: if (start_i) begin
                    w_q  <= cfg_width_i;
                    h_q  <= cfg_height_i;
                    npix <= npix_c[ADDR_WIDTH:0];
                    idx  <= '0;
                    if (size_bad) begin
                        err_o <= 1'b1;
                    end else begin
                        state     <= S_LOAD;
                        s_ready_o <= 1'b1;
                    end
                end
                // Ready drops on the edge that takes the last pixel, so no extra beat slips in.
                S_LOAD: if (in_hs) begin
                    idx <= idx_next;
                    if (idx_next == npix) begin
                        s_ready_o <= 1'b0;
                        state     <= S_CFG_W;
                    end
                end
                S_CFG_W: state <= S_CFG_H;
                S_CFG_H: state <= S_START;
                S_START: begin
                    poll_cnt <= '0;
                    state    <= S_POLL_REQ;
                end
                S_POLL_REQ: state <= S_POLL_WAIT;
                S_POLL_WAIT: if (rdata_valid) begin
                    if (rdata == FULL_BIT_WIDTH'(1)) begin
                        idx   <= '0;
                        state <= S_RD_REQ;
                    end else if (poll_cnt == POLL_W'(POLL_TIMEOUT - 1)) begin
                        err_o <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                        state    <= S_POLL_REQ;
                    end
                end
                S_RD_REQ: state <= S_RD_WAIT;
                S_RD_WAIT: if (rdata_valid) begin
                    m_valid_o <= 1'b1;
                    m_last_o  <= (idx_next == npix);
                    state     <= S_RD_OUT;
                end
                S_RD_OUT: if (m_ready_i) begin
                    m_valid_o <= 1'b0;
                    m_last_o  <= 1'b0;
                    idx       <= idx_next;
                    if (m_last_o) begin
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        state <= S_RD_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output pixel register carries data only; its qualifier is m_valid_o.
    always_ff @(posedge CLK) begin
        if (state == S_RD_WAIT && rdata_valid) begin
            m_data_o <= rdata[BIT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_median_filter_host_bridge.sv
// Bench for median_filter_host_bridge with a behavioural filter model (memory, output = input ^ 0xFF).
module tb_median_filter_host_bridge;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] cfg_width_i = '0, cfg_height_i = '0;
    logic       start_i = 1'b0, busy_o, done_o, err_o;
    logic [7:0] s_data_i = '0, m_data_o;
    logic       s_valid_i = 1'b0, s_ready_o, m_valid_o, m_last_o, m_ready_i = 1'b0;

    always #5 CLK = ~CLK;

    median_filter_host_bridge_if #(.ADDR_WIDTH(18), .MODE_ADDR_WIDTH(2), .FULL_BIT_WIDTH(32)) bus ();

    median_filter_host_bridge #(.POLL_TIMEOUT(100)) dut (
        .CLK(CLK), .RST(RST), .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .fport(bus)
    );

    int n_tests = 0, n_fail = 0;

    // Filter model: pixel memory, start/done control with a 50-cycle run.
    logic [7:0]  pix_mem [0:262143];
    logic [31:0] douta_m = '0;
    int          run_cnt = 0;
    logic        f_done = 1'b0;
    bit          never_done = 0;
    assign bus.douta_i = douta_m;

    always @(posedge CLK) begin
        if (run_cnt > 0) begin
            run_cnt <= run_cnt - 1;
            if (run_cnt == 1 && !never_done) f_done <= 1'b1;
        end
        if (bus.ena_o) begin
            if (bus.wea_o) begin
                if (bus.addra_o[19:18] == 2'b00) pix_mem[bus.addra_o[17:0]] <= bus.dina_o[7:0];
                if (bus.addra_o[19:18] == 2'b01 && bus.dina_o == 32'd1) begin
                    run_cnt <= 50;
                    f_done  <= 1'b0;
                end
            end else begin
                case (bus.addra_o[19:18])
                    2'b00:   douta_m <= {24'h0, pix_mem[bus.addra_o[17:0]] ^ 8'hFF};
                    2'b01:   douta_m <= {31'h0, f_done};
                    default: douta_m <= '0;
                endcase
            end
        end
    end

    // Port monitor
    int wr_addr_q[$], wr_data_q[$];
    int poll_reads = 0, ena_cnt = 0;
    always @(negedge CLK) begin
        if (bus.ena_o) begin
            ena_cnt++;
            if (bus.wea_o) begin
                wr_addr_q.push_back(int'(bus.addra_o));
                wr_data_q.push_back(int'(bus.dina_o));
            end else if (bus.addra_o[19:18] == 2'b01) begin
                poll_reads++;
            end
        end
    end

    logic [7:0] img[$];
    logic [7:0] out_q[$];
    bit         out_last_q[$];
    bit         seen_done, seen_err, timed_out, stall_unstable;
    int         stall_ena, stall_cnt, acc_last_cyc, done_cyc;

    task automatic fill_img(input int n, input bit ramp);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    // Drives one whole frame; vmode 0=always valid, 1=toggle, 2=random; rmode 0=ready, 1=stall on beat 3, 2=random.
    task automatic run_frame(input int w, input int h, input int vmode, input int rmode, input int budget);
        int cyc = 0, in_idx = 0, npix = w * h;
        logic [7:0] held;
        out_q.delete(); out_last_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        poll_reads = 0; ena_cnt = 0; seen_done = 0; seen_err = 0; timed_out = 0;
        stall_unstable = 0; stall_ena = 0; stall_cnt = 0; acc_last_cyc = -1; done_cyc = -1;
        held = '0;
        @(negedge CLK);
        cfg_width_i = 10'(w); cfg_height_i = 10'(h); start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        forever begin
            if (done_o) begin seen_done = 1; done_cyc = cyc; break; end
            if (err_o) begin seen_err = 1; break; end
            if (cyc >= budget) begin timed_out = 1; break; end
            case (vmode)
                0:       s_valid_i = (in_idx < npix);
                1:       s_valid_i = (in_idx < npix) && (cyc % 2 == 0);
                default: s_valid_i = (in_idx < npix) && ($urandom_range(0, 1) == 1);
            endcase
            s_data_i = (in_idx < npix) ? img[in_idx] : 8'h00;
            if (rmode == 1 && m_valid_o && out_q.size() == 3 && stall_cnt < 5) begin
                m_ready_i = 1'b0;
                if (stall_cnt == 0) held = m_data_o;
                else if (m_data_o !== held) stall_unstable = 1;
                stall_ena += int'(bus.ena_o);
                stall_cnt++;
            end else begin
                m_ready_i = (rmode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (s_valid_i && s_ready_o) in_idx++;
            if (m_valid_o && m_ready_i) begin
                out_q.push_back(m_data_o);
                out_last_q.push_back(m_last_o);
                acc_last_cyc = cyc;
            end
            @(negedge CLK);
            cyc++;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
    endtask

    // Mismatch counts of the observed streams against the bridge's defined behaviour.
    function automatic int wr_errors(input int w, input int h);
        int e = 0, n = w * h;
        if (wr_addr_q.size() != n + 3) return 1000000;
        for (int i = 0; i < n; i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != int'(img[i])) e++;
        if (wr_addr_q[n] != 'h80000 || wr_data_q[n] != w) e++;
        if (wr_addr_q[n+1] != 'hC0000 || wr_data_q[n+1] != h) e++;
        if (wr_addr_q[n+2] != 'h40000 || wr_data_q[n+2] != 1) e++;
        return e;
    endfunction

    function automatic int out_errors(input int n);
        int e = 0;
        if (out_q.size() != n) return 1000000;
        for (int i = 0; i < n; i++)
            if (out_q[i] !== (img[i] ^ 8'hFF) || out_last_q[i] !== (i == n - 1)) e++;
        return e;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if ({bus.ena_o, bus.wea_o, s_ready_o, m_valid_o, m_last_o, busy_o, done_o, err_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {bus.ena_o, bus.wea_o, s_ready_o, m_valid_o, m_last_o, busy_o, done_o, err_o});
        end
        n_tests++;
        if (bus.dina_o !== 32'h0) begin n_fail++; $display("FAIL reset_dina: got %h required 0", bus.dina_o); end
        n_tests++;
        if (bus.addra_o !== 20'h0) begin n_fail++; $display("FAIL reset_addra: got %h required 0", bus.addra_o); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic_4x3();
        int e;
        fill_img(12, 1);
        run_frame(4, 3, 0, 0, 3000);
        n_tests++;
        if (timed_out || !seen_done || seen_err) begin
            n_fail++; $display("FAIL basic_end: to=%0d done=%0d err=%0d required 0 1 0", timed_out, seen_done, seen_err);
        end
        n_tests++;
        if (wr_addr_q.size() != 15) begin n_fail++; $display("FAIL basic_wr_count: got %0d required 15", wr_addr_q.size()); end
        e = wr_errors(4, 3);
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL basic_wr_seq: mismatches %0d required 0", e); end
        n_tests++;
        if (poll_reads < 2) begin n_fail++; $display("FAIL basic_polls: got %0d required >=2", poll_reads); end
        e = out_errors(12);
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL basic_out_seq: mismatches %0d required 0", e); end
        n_tests++;
        if (done_cyc - acc_last_cyc != 1) begin
            n_fail++; $display("FAIL basic_done_timing: got %0d cycles required 1", done_cyc - acc_last_cyc);
        end
        @(negedge CLK);
        n_tests++;
        if ({done_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: got %b required 00", {done_o, busy_o}); end
    endtask

    task automatic test_stall();
        int e;
        fill_img(12, 0);
        run_frame(4, 3, 0, 1, 3000);
        n_tests++;
        if (stall_cnt != 5 || stall_unstable) begin
            n_fail++; $display("FAIL stall_hold: cycles %0d unstable %0d required 5 0", stall_cnt, stall_unstable);
        end
        n_tests++;
        if (stall_ena != 0) begin n_fail++; $display("FAIL stall_port_idle: got %0d ena cycles required 0", stall_ena); end
        e = out_errors(12);
        n_tests++;
        if (e != 0 || !seen_done) begin n_fail++; $display("FAIL stall_out_seq: mismatches %0d done %0d required 0 1", e, seen_done); end
    endtask

    task automatic test_gaps();
        int e;
        fill_img(43 * 55, 0);
        run_frame(43, 55, 1, 0, 40000);
        n_tests++;
        if (wr_addr_q.size() != 43 * 55 + 3) begin
            n_fail++; $display("FAIL gaps_wr_count: got %0d required %0d", wr_addr_q.size(), 43 * 55 + 3);
        end
        e = wr_errors(43, 55);
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL gaps_wr_seq: mismatches %0d required 0", e); end
        e = out_errors(43 * 55);
        n_tests++;
        if (e != 0 || !seen_done) begin n_fail++; $display("FAIL gaps_out_seq: mismatches %0d done %0d required 0 1", e, seen_done); end
    endtask

    task automatic test_bad_size();
        int ws[3] = '{0, 4, 1023};
        int hs[3] = '{3, 0, 1023};
        logic e1, e2, b1, b2;
        int  ena0;
        for (int k = 0; k < 3; k++) begin
            ena0 = ena_cnt;
            @(negedge CLK);
            cfg_width_i = 10'(ws[k]); cfg_height_i = 10'(hs[k]); start_i = 1'b1;
            @(negedge CLK);
            start_i = 1'b0; e1 = err_o; b1 = busy_o;
            @(negedge CLK);
            e2 = err_o; b2 = busy_o;
            repeat (3) @(negedge CLK);
            n_tests++;
            if ({e1, e2, b1, b2} !== 4'b1000 || ena_cnt != ena0) begin
                n_fail++;
                $display("FAIL bad_size_%0d: err %b%b busy %b%b ena %0d required err 10 busy 00 ena 0",
                         k, e1, e2, b1, b2, ena_cnt - ena0);
            end
        end
        // Exactly 2^ADDR_WIDTH pixels is a legal frame.
        @(negedge CLK);
        cfg_width_i = 10'd512; cfg_height_i = 10'd512; start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        n_tests++;
        if ({busy_o, err_o, s_ready_o} !== 3'b101) begin
            n_fail++; $display("FAIL max_size_accept: busy/err/ready %b required 101", {busy_o, err_o, s_ready_o});
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_timeout();
        fill_img(4, 0);
        never_done = 1;
        run_frame(2, 2, 0, 0, 3000);
        never_done = 0;
        n_tests++;
        if (!seen_err || seen_done || out_q.size() != 0) begin
            n_fail++; $display("FAIL timeout_err: err %0d done %0d beats %0d required 1 0 0", seen_err, seen_done, out_q.size());
        end
        n_tests++;
        if (poll_reads != 100) begin n_fail++; $display("FAIL timeout_polls: got %0d required 100", poll_reads); end
        @(negedge CLK);
        n_tests++;
        if ({busy_o, err_o} !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: busy/err %b required 00", {busy_o, err_o}); end
    endtask

    task automatic test_reset_mid_load();
        int n = 0, guard = 0, ena0, e;
        fill_img(12, 0);
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge CLK);
        cfg_width_i = 10'd4; cfg_height_i = 10'd3; start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        while (n < 5 && guard < 50) begin
            s_valid_i = 1'b1; s_data_i = img[n];
            if (s_ready_o) n++;
            @(negedge CLK);
            guard++;
        end
        s_valid_i = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_tests++;
        if (wr_addr_q.size() != 5) begin n_fail++; $display("FAIL midload_pre_writes: got %0d required 5", wr_addr_q.size()); end
        n_tests++;
        if ({bus.ena_o, bus.wea_o, s_ready_o, m_valid_o, m_last_o, busy_o, done_o, err_o, bus.dina_o, bus.addra_o} !== 60'h0) begin
            n_fail++; $display("FAIL midload_reset_outputs: ena %b ready %b busy %b addra %h required all 0",
                               bus.ena_o, s_ready_o, busy_o, bus.addra_o);
        end
        @(negedge CLK);
        RST = 1'b0;
        ena0 = ena_cnt;
        repeat (4) @(negedge CLK);
        n_tests++;
        if (ena_cnt != ena0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL midload_quiet: ena %0d busy %b required 0 0", ena_cnt - ena0, busy_o);
        end
        fill_img(12, 0);
        run_frame(4, 3, 2, 0, 3000);
        e = wr_errors(4, 3);
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL midload_reload: mismatches %0d required 0", e); end
        e = out_errors(12);
        n_tests++;
        if (e != 0 || !seen_done) begin n_fail++; $display("FAIL midload_out: mismatches %0d done %0d required 0 1", e, seen_done); end
    endtask

    task automatic test_random();
        int w, h, e1, e2;
        for (int it = 0; it < 4; it++) begin
            w = $urandom_range(1, 7);
            h = $urandom_range(1, 7);
            fill_img(w * h, 0);
            run_frame(w, h, $urandom_range(0, 2), 2, 5000);
            e1 = wr_errors(w, h);
            e2 = out_errors(w * h);
            n_tests++;
            if (e1 != 0 || e2 != 0 || !seen_done || timed_out) begin
                n_fail++; $display("FAIL random_%0d (%0dx%0d): wr %0d out %0d done %0d to %0d required 0 0 1 0",
                                   it, w, h, e1, e2, seen_done, timed_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_4x3();
        test_stall();
        test_bad_size();
        test_timeout();
        test_reset_mid_load();
        test_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
